// File: rtl/ula_pkg.sv
// ula_pkg: shared constants and types for the ALU flag generator.
//   Sel codes, flag bit positions inside the 5-bit flag vector, and the
//   error-lock FSM state type.
package ula_pkg;
    localparam logic [2:0] SEL_ADD = 3'b000;
    localparam logic [2:0] SEL_SUB = 3'b001;
    localparam logic [2:0] SEL_MUL = 3'b010;
    localparam logic [2:0] SEL_DIV = 3'b011;

    localparam int FLG_Z    = 0;
    localparam int FLG_OV   = 1;
    localparam int FLG_COUT = 2;
    localparam int FLG_ERR  = 3;
    localparam int FLG_R    = 4;
    localparam int NFLAGS   = 5;

    typedef enum logic {ST_RUN, ST_LOCKED} state_t;
endpackage

// File: rtl/flags_ula_comb.sv
// flags_ula_comb: combinational ALU flag equations.
//   S, B, resto_div : WIDTH-bit result, divisor, remainder
//   Sel             : operation select
//   soma_*, sub_*   : adder carries / subtractor borrows around the MSB
//   multi_sat       : multiplier saturation
//   flags           : {R,ERR,COUT,OV,Z}
module flags_ula_comb
    import ula_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]  S,
    input  logic [WIDTH-1:0]  B,
    input  logic [2:0]        Sel,
    input  logic              soma_cmsb,
    input  logic              soma_cout,
    input  logic              sub_bmsb,
    input  logic              sub_bout,
    input  logic [WIDTH-1:0]  resto_div,
    input  logic              multi_sat,
    output logic [NFLAGS-1:0] flags
);
    logic is_div;
    logic div_zero;

    assign is_div   = (Sel == SEL_DIV);
    assign div_zero = is_div && (B == '0);

    always_comb begin
        flags           = '0;
        flags[FLG_Z]    = (S == '0);
        flags[FLG_COUT] = (Sel == SEL_ADD) ? soma_cout :
                          (Sel == SEL_SUB) ? sub_bout  : 1'b0;
        flags[FLG_OV]   = (Sel == SEL_ADD) ? (soma_cmsb ^ soma_cout) :
                          (Sel == SEL_SUB) ? (sub_bmsb ^ sub_bout)   :
                          (Sel == SEL_MUL) ? multi_sat               : 1'b0;
        flags[FLG_ERR]  = div_zero;
        // A remainder is meaningless when the divisor was zero, so R is masked.
        flags[FLG_R]    = is_div && (resto_div != '0) && !div_zero;
    end
endmodule

// File: rtl/flags_ula_seq.sv
// flags_ula_seq: registered ALU flags with sticky copies, saturating event
// counters and an optional divide-by-zero lock.
//   clk, rst_n         : clock, async active-low reset
//   valid_in/ready_out : accept handshake (ready_out low only while LOCKED)
//   S..multi_sat       : ALU result and side signals, see flags_ula_comb
//   clr_sticky         : clears sticky and both counters
//   ack_err            : releases LOCKED
//   flags/valid_out    : registered {R,ERR,COUT,OV,Z} and its update strobe
//   sticky             : OR-accumulated flags
//   ov_cnt/err_cnt     : saturating counts of accepted OV / ERR ops
//   locked             : FSM is in LOCKED
module flags_ula_seq
    import ula_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CNT_W       = 8,
    parameter bit LOCK_ON_ERR = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [WIDTH-1:0]  S,
    input  logic [WIDTH-1:0]  B,
    input  logic [2:0]        Sel,
    input  logic              soma_cmsb,
    input  logic              soma_cout,
    input  logic              sub_bmsb,
    input  logic              sub_bout,
    input  logic [WIDTH-1:0]  resto_div,
    input  logic              multi_sat,
    input  logic              clr_sticky,
    input  logic              ack_err,
    output logic [NFLAGS-1:0] flags,
    output logic              valid_out,
    output logic [NFLAGS-1:0] sticky,
    output logic [CNT_W-1:0]  ov_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              locked
);
    logic [NFLAGS-1:0] new_flags;
    logic              accept;
    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  ov_base;
    logic [CNT_W-1:0]  err_base;
    logic [CNT_W-1:0]  ov_nx;
    logic [CNT_W-1:0]  err_nx;

    flags_ula_comb #(.WIDTH(WIDTH)) u_comb (
        .S         (S),
        .B         (B),
        .Sel       (Sel),
        .soma_cmsb (soma_cmsb),
        .soma_cout (soma_cout),
        .sub_bmsb  (sub_bmsb),
        .sub_bout  (sub_bout),
        .resto_div (resto_div),
        .multi_sat (multi_sat),
        .flags     (new_flags)
    );

    assign accept = valid_in && ready_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!LOCK_ON_ERR)
            state_nx = ST_RUN;
        else if (state == ST_LOCKED)
            state_nx = ack_err ? ST_RUN : ST_LOCKED;
        else if (accept && new_flags[FLG_ERR])
            state_nx = ST_LOCKED;
    end

    always_comb begin
        ready_out = (state == ST_RUN);
        locked    = (state == ST_LOCKED);
    end

    // Clear is applied first, then the accepted op contributes on top of it.
    always_comb begin
        ov_base  = clr_sticky ? '0 : ov_cnt;
        err_base = clr_sticky ? '0 : err_cnt;
        ov_nx    = (accept && new_flags[FLG_OV]  && ov_base  != '1) ? ov_base  + CNT_W'(1) : ov_base;
        err_nx   = (accept && new_flags[FLG_ERR] && err_base != '1) ? err_base + CNT_W'(1) : err_base;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags     <= '0;
            valid_out <= 1'b0;
            sticky    <= '0;
            ov_cnt    <= '0;
            err_cnt   <= '0;
        end else begin
            valid_out <= accept;
            if (accept) flags <= new_flags;
            sticky    <= (clr_sticky ? '0 : sticky) | (accept ? new_flags : '0);
            ov_cnt    <= ov_nx;
            err_cnt   <= err_nx;
        end
    end
endmodule
